mc_control_fsm: RTL

//  Multicycle MIPS control FSM with memory-ready handshake: stalls in memory states until mem_rdy.

---
 rtl/mc_control_fsm_if.sv | 38 +++
 rtl/mc_control_fsm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The master side is the controller: it receives the instruction word and the
// memory-ready strobe, and drives every datapath select, enable and trap flag.
interface mc_control_fsm_if;
    logic [31:0] Instr;
    logic        mem_rdy;
    logic        mem_req;
    logic        MemtoReg;
    logic        IorD;
    logic [1:0]  RegDst;
    logic [1:0]  PCSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IRWrite;
    logic        MemWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  Branch;
    logic        ExtOp;
    logic [3:0]  ALUControl;
    logic        illegal;
    logic        timeout;
    logic [3:0]  state_dbg;

    modport master (
        input  Instr, mem_rdy,
        output mem_req, MemtoReg, IorD, RegDst, PCSrc, ALUSrcA, ALUSrcB,
               IRWrite, MemWrite, PCWrite, RegWrite, Branch, ExtOp,
               ALUControl, illegal, timeout, state_dbg
    );

    modport slave (
        output Instr, mem_rdy,
        input  mem_req, MemtoReg, IorD, RegDst, PCSrc, ALUSrcA, ALUSrcB,
               IRWrite, MemWrite, PCWrite, RegWrite, Branch, ExtOp,
               ALUControl, illegal, timeout, state_dbg
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with a memory-ready handshake.
// Memory states stall until mem_rdy; a per-access wait counter raises a sticky
// timeout trap, and undecodable instructions raise a sticky illegal trap.
// Optional feature macro: MC_CTRL_JAL_EN adds the JAL (opcode 3) and JR
// (R-type funct 8) states; without it both encodings trap as illegal.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic             cclk,
    input  logic             rstb,
    mc_control_fsm_if.master ctrl
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_JR    = 6'd8;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MEM_TIMEOUT);
    localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_ITYPE_EX  = 4'd9,
        S_ITYPE_WB  = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_ERROR     = 4'd14
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       functOk;
    logic       memReq;
    logic       waiting;
    logic       trap;

    assign opcode  = ctrl.Instr[31:26];
    assign funct   = ctrl.Instr[5:0];
    assign memReq  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign waiting = memReq && !ctrl.mem_rdy;
    assign trap    = TMO_EN && waiting && (cnt_q == TMO_CNT);

    // Recognise the R-type function codes this controller can execute.
    always_comb begin
        functOk = 1'b0;
        case (funct)
            6'd0, 6'd2, 6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42: functOk = 1'b1;
`ifdef MC_CTRL_JAL_EN
            FN_JR: functOk = 1'b1;
`endif
            default: functOk = 1'b0;
        endcase
    end

    // Next state, wait-counter and sticky trap flags; a ready strobe in the
    // cycle the counter hits the limit still completes the access.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        cnt_d     = waiting ? ((cnt_q == TMO_CNT) ? cnt_q : cnt_q + 1'b1) : '0;
        case (state_q)
            S_FETCH: begin
                if (trap) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else if (ctrl.mem_rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE: begin
                        if (!functOk) begin
                            state_d   = S_ERROR;
                            illegal_d = 1'b1;
                        end
`ifdef MC_CTRL_JAL_EN
                        else if (funct == FN_JR) begin
                            state_d = S_JR;
                        end
`endif
                        else begin
                            state_d = S_EXECUTE;
                        end
                    end
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_ITYPE_EX;
                    OP_J: state_d = S_JUMP;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL: state_d = S_JAL;
`endif
                    default: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (trap) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else if (ctrl.mem_rdy) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WRITE: begin
                if (trap) begin
                    state_d   = S_ERROR;
                    timeout_d = 1'b1;
                end else if (ctrl.mem_rdy) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE:  state_d = S_ALU_WB;
            S_ITYPE_EX: state_d = S_ITYPE_WB;
            S_MEM_WB, S_ALU_WB, S_ITYPE_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, wait counter and trap flags; reset restarts at FETCH.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore decode of the datapath controls; MemWrite is also held off while
    // reset is asserted so an aborted store never reaches memory.
    always_comb begin
        ctrl.mem_req    = 1'b0;
        ctrl.MemtoReg   = 1'b0;
        ctrl.IorD       = 1'b0;
        ctrl.RegDst     = 2'd0;
        ctrl.PCSrc      = 2'd0;
        ctrl.ALUSrcA    = 2'd0;
        ctrl.ALUSrcB    = 2'd0;
        ctrl.IRWrite    = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.PCWrite    = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.Branch     = 2'b00;
        ctrl.ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.ALUSrcB = 2'd1;
                ctrl.IRWrite = ctrl.mem_rdy;
                ctrl.PCWrite = ctrl.mem_rdy;
            end
            S_DECODE: ctrl.ALUSrcB = 2'd3;
            S_MEM_ADR: begin
                ctrl.ALUSrcA = 2'd1;
                ctrl.ALUSrcB = 2'd2;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.MemtoReg = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req  = 1'b1;
                ctrl.IorD     = 1'b1;
                ctrl.MemWrite = ctrl.mem_rdy && rstb;
            end
            S_EXECUTE: begin
                ctrl.ALUSrcA = 2'd1;
                case (funct)
                    6'd0:    ctrl.ALUControl = ALU_SLL;
                    6'd2:    ctrl.ALUControl = ALU_SRL;
                    6'd34:   ctrl.ALUControl = ALU_SUB;
                    6'd36:   ctrl.ALUControl = ALU_AND;
                    6'd37:   ctrl.ALUControl = ALU_OR;
                    6'd38:   ctrl.ALUControl = ALU_XOR;
                    6'd39:   ctrl.ALUControl = ALU_NOR;
                    6'd42:   ctrl.ALUControl = ALU_SLT;
                    default: ctrl.ALUControl = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                ctrl.RegDst   = 2'd1;
                ctrl.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.ALUSrcA    = 2'd1;
                ctrl.ALUControl = ALU_SUB;
                ctrl.PCSrc      = 2'd1;
                ctrl.Branch     = (opcode == OP_BNE) ? 2'b10 : 2'b01;
            end
            S_ITYPE_EX: begin
                ctrl.ALUSrcA = 2'd1;
                ctrl.ALUSrcB = 2'd2;
                case (opcode)
                    OP_SLTI: ctrl.ALUControl = ALU_SLT;
                    OP_ANDI: ctrl.ALUControl = ALU_AND;
                    OP_ORI:  ctrl.ALUControl = ALU_OR;
                    OP_XORI: ctrl.ALUControl = ALU_XOR;
                    default: ctrl.ALUControl = ALU_ADD;
                endcase
            end
            S_ITYPE_WB: ctrl.RegWrite = 1'b1;
            S_JUMP: begin
                ctrl.PCSrc   = 2'd2;
                ctrl.PCWrite = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            S_JAL: begin
                ctrl.ALUSrcB  = 2'd1;
                ctrl.RegDst   = 2'd2;
                ctrl.RegWrite = 1'b1;
                ctrl.PCSrc    = 2'd2;
                ctrl.PCWrite  = 1'b1;
            end
            S_JR: begin
                ctrl.PCSrc   = 2'd3;
                ctrl.PCWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctrl.ExtOp     = !((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI));
    assign ctrl.illegal   = illegal_q;
    assign ctrl.timeout   = timeout_q;
    assign ctrl.state_dbg = state_q;

endmodule
